neural_layer_seq: RTL and testbench



---
 rtl/neural_layer_seq.sv | 187 ++++++++++++++++++
 tb/tb_neural_layer_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/neural_layer_seq.sv
`default_nettype none
// ============================================================================
// neural_layer_seq : feeds N_IN input/weight terms plus a bias per neuron into
//                    the neural MAC and presents each result on valid/ready.
// Optional feature : NEURAL_SEQ_RELU_EN (clamp negative results to zero).
// Revision         : 1.0
// ============================================================================
module neural_layer_seq #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8,
    parameter int IAW   = 8,
    parameter int WAW   = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [IAW-1:0] in_addr,
    input  logic [15:0]    in_data,
    output logic [WAW-1:0] w_addr,
    input  logic [15:0]    w_data,
    output logic           mac_zero,
    output logic           mac_isbias,
    output logic [15:0]    mac_in,
    output logic [15:0]    mac_w,
    output logic [15:0]    mac_last,
    input  logic [15:0]    mac_acc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_idx,
    output logic [15:0]    out_data
);

    localparam int             KW        = $clog2(N_IN + 1);
    localparam int             JW        = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [KW-1:0]  K_BIAS    = KW'(N_IN);
    localparam logic [JW-1:0]  J_LAST    = JW'(N_OUT - 1);
    localparam logic [WAW-1:0] BASE_STEP = WAW'(N_IN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [JW-1:0]  j_q, j_d;
    logic [WAW-1:0] base_q, base_d;
    logic           drain_q, drain_d;
    logic           valid_q, valid_d;
    logic [7:0]     idx_q, idx_d;
    logic [15:0]    data_q, data_d;
    logic           tv_q, tv_d;
    logic           first_q, first_d;
    logic           bias_q, bias_d;
    logic [15:0]    capture_val;

`ifdef NEURAL_SEQ_RELU_EN
    assign capture_val = mac_acc[15] ? 16'd0 : mac_acc;
`else
    assign capture_val = mac_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            base_q  <= '0;
            drain_q <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            tv_q    <= 1'b0;
            first_q <= 1'b0;
            bias_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            base_q  <= base_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tv_q    <= tv_d;
            first_q <= first_d;
            bias_q  <= bias_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        base_d  = base_q;
        drain_d = drain_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tv_d    = 1'b0;
        first_d = 1'b0;
        bias_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    j_d     = '0;
                    base_d  = '0;
                end
            end
            S_ISSUE: begin
                // Flags travel one cycle behind the address to meet the read data.
                tv_d    = 1'b1;
                first_d = (k_q == '0);
                bias_d  = (k_q == K_BIAS);
                if (k_q == K_BIAS) begin
                    k_d     = '0;
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    data_d  = capture_val;
                    idx_d   = 8'(j_q);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (j_q == J_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        j_d     = j_q + 1'b1;
                        base_d  = base_q + BASE_STEP;
                        k_d     = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_OUT);
    assign done      = (state_q == S_FIN);
    assign in_addr   = ((state_q == S_ISSUE) && (k_q != K_BIAS)) ? IAW'(k_q) : '0;
    assign w_addr    = (state_q == S_ISSUE) ? (base_q + WAW'(k_q)) : '0;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;

    // Idle terms feed zero operands back with the current sum so the MAC holds.
    always_comb begin
        mac_in     = 16'd0;
        mac_w      = 16'd0;
        mac_isbias = 1'b0;
        mac_zero   = 1'b0;
        mac_last   = mac_acc;
        if (tv_q) begin
            mac_in     = in_data;
            mac_w      = w_data;
            mac_isbias = bias_q;
            mac_zero   = first_q;
            mac_last   = first_q ? 16'd0 : mac_acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neural_layer_seq.sv
`default_nettype none
// ============================================================================
// tb_neural_layer_seq : directed and randomized layers against a reference
//                       dot-product model, with a behavioural MAC and memories.
// Revision            : 1.0
// ============================================================================
module tb_neural_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int IAW   = 8;
    localparam int WAW   = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic [IAW-1:0] in_addr;
    logic [15:0]    in_data;
    logic [WAW-1:0] w_addr;
    logic [15:0]    w_data;
    logic           mac_zero;
    logic           mac_isbias;
    logic [15:0]    mac_in;
    logic [15:0]    mac_w;
    logic [15:0]    mac_last;
    logic [15:0]    mac_acc = 16'hBEEF;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     out_idx;
    logic [15:0]    out_data;

    logic [15:0] in_mem [0:255];
    logic [15:0] w_mem  [0:4095];
    logic [15:0] x      [N_IN];
    logic [15:0] wt     [N_OUT][N_IN];
    logic [15:0] bias   [N_OUT];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    neural_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .IAW(IAW), .WAW(WAW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .mac_zero   (mac_zero),
        .mac_isbias (mac_isbias),
        .mac_in     (mac_in),
        .mac_w      (mac_w),
        .mac_last   (mac_last),
        .mac_acc    (mac_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_data   (out_data)
    );

    // Environment: synchronous-read memories and the neural MAC.
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        mac_acc <= (mac_zero ? 16'd0 : mac_last)
                 + (mac_isbias ? 16'(mac_w * 16'd4) : 16'(mac_in * mac_w));
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_neuron(input int j);
        logic [31:0] s;
        logic [15:0] r;
        s = 32'd0;
        for (int i = 0; i < N_IN; i++) s = s + x[i] * wt[j][i];
        s = s + 32'd4 * bias[j];
        r = s[15:0];
`ifdef NEURAL_SEQ_RELU_EN
        if (r[15]) r = 16'd0;
`endif
        return r;
    endfunction

    task automatic load_mems();
        for (int i = 0; i < N_IN; i++) in_mem[i] = x[i];
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) w_mem[j*(N_IN+1)+i] = wt[j][i];
            w_mem[j*(N_IN+1)+N_IN] = bias[j];
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {27'd0, busy, done, out_valid, mac_zero, mac_isbias}, 32'd0);
        check({tag, "_addr"}, {12'd0, in_addr, w_addr}, 32'd0);
        check({tag, "_out"}, {8'd0, out_idx, out_data}, 32'd0);
    endtask

    task automatic run_layer(input int stall0, input bit glitch);
        int          n;
        int          d0;
        int          h0;
        logic [15:0] exp;
        logic [15:0] acc_hold;
        load_mems();
        d0 = done_cnt;
        h0 = hs_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin
            check("issue_busy", busy, 1);
            check("issue_waddr", w_addr, j * (N_IN + 1));
            check("issue_inaddr", in_addr, 0);
            if (glitch && j == 1) begin
                start     = 1'b1;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = 1'b0;
            n = 1;
            while (!out_valid && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            exp = ref_neuron(j);
            check("latency", n, N_IN + 3);
            check("out_idx", out_idx, j);
            check("out_data", out_data, exp);
            acc_hold = mac_acc;
            for (int s = 0; s < ((j == 0) ? stall0 : 0); s++) begin
                @(posedge clk); #1;
                check("stall_valid", out_valid, 1);
                check("stall_data", {out_idx, out_data}, {8'(j), exp});
                check("stall_acc", mac_acc, acc_hold);
                check("stall_waddr", w_addr, 0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("valid_drop", out_valid, 0);
        end
        check("fin_done", {busy, done}, 2'b01);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fin_start_ignored", {busy, done}, 2'b00);
        check("done_pulses", done_cnt - d0, 1);
        check("handshakes", hs_cnt - h0, N_OUT);
    endtask

    task automatic set_directed();
        for (int i = 0; i < N_IN; i++) x[i] = 16'(i + 1);
        for (int i = 0; i < N_IN; i++) wt[0][i] = 16'd1;
        wt[1][0] = 16'd2; wt[1][1] = 16'd0; wt[1][2] = 16'd0; wt[1][3] = 16'd1;
        bias[0] = 16'd2;
        bias[1] = 16'd0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) in_mem[i] = 16'(i * 37 + 5);
        for (int i = 0; i < 4096; i++) w_mem[i] = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed layer: 18 then 6, no stall.
        set_directed();
        run_layer(0, 1'b0);
        // Downstream stall on neuron 0.
        run_layer(10, 1'b0);
        // Stray start and early ready during neuron 1.
        run_layer(0, 1'b1);

        // Reset while draining neuron 0.
        load_mems();
        begin
            int d0;
            d0 = done_cnt;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (N_IN + 2) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check_quiet("async_rst");
            @(posedge clk); #1;
            check_quiet("rst_edge");
            rst = 1'b0;
            @(posedge clk); #1;
            check("rst_no_done", done_cnt - d0, 0);
        end
        run_layer(0, 1'b0);

        // Negative accumulator: 0xFF0A, or 0 with ReLU.
        set_directed();
        bias[0] = 16'hFFC0;
        run_layer(3, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_IN; i++) x[i] = 16'($urandom);
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) wt[j][i] = 16'($urandom);
                bias[j] = 16'($urandom);
            end
            run_layer(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
